// File: rtl/inta_cycle_sequencer.sv
// Interrupt-acknowledge sequencer: turns the PIC INT request into an INTA pulse train,
// captures the vector bytes the PIC drives, and hands them to the CPU via valid/ack.
module inta_cycle_sequencer #(
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned GAP_W     = 2,
  parameter bit          MODE_8080 = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        int_enable,
  input  logic [7:0]  sys_DataLine,
  input  logic        vector_ack,
  output logic        INTA,
  output logic        LOCK,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  vector,
  output logic [15:0] call_addr,
  output logic        spurious
);

  localparam int unsigned MaxW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CntW = $clog2(MaxW) + 1;
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_W - 1);
  localparam logic [7:0] CallOpcode = 8'hCD;

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StG1,
    StP2,
    StG2,
    StP3,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            int_q;
  logic [7:0]      vector_q, vector_d;
  logic [15:0]     call_addr_q, call_addr_d;
  logic            spurious_q, spurious_d;

  // INT is only ever looked at through this single register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_q       <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      vector_q    <= '0;
      call_addr_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      int_q       <= INT;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vector_q    <= vector_d;
      call_addr_q <= call_addr_d;
      spurious_q  <= spurious_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    vector_d    = vector_q;
    call_addr_d = call_addr_q;
    spurious_d  = spurious_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (int_q && int_enable && !vector_valid) begin
          state_d = StP1;
        end
      end
      StP1: begin
        if (cnt_q == PulseLast) begin
          state_d = StG1;
          if (MODE_8080) begin
            vector_d   = sys_DataLine;
            spurious_d = (sys_DataLine != CallOpcode);
          end else begin
            // Request withdrawn during the first pulse marks the vector spurious.
            spurious_d = !int_q;
          end
        end
      end
      StG1: begin
        if (cnt_q == GapLast) begin
          state_d = StP2;
        end
      end
      StP2: begin
        if (cnt_q == PulseLast) begin
          if (MODE_8080) begin
            call_addr_d[7:0] = sys_DataLine;
            state_d          = StG2;
          end else begin
            vector_d = sys_DataLine;
            state_d  = StDone;
          end
        end
      end
      StG2: begin
        if (cnt_q == GapLast) begin
          state_d = StP3;
        end
      end
      StP3: begin
        if (cnt_q == PulseLast) begin
          call_addr_d[15:8] = sys_DataLine;
          state_d           = StDone;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (vector_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Strobes decode straight from the state register, so they change only on clock edges.
  always_comb begin
    INTA         = !(state_q inside {StP1, StP2, StP3});
    LOCK         = !(!MODE_8080 && (state_q inside {StP1, StG1, StP2}));
    busy         = (state_q != StIdle);
    vector_valid = (state_q == StDone);
    vector       = vector_q;
    call_addr    = call_addr_q;
    spurious     = spurious_q;
  end

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Randomized bench: an 8086-mode and an 8080-mode sequencer share stimulus and are checked
// against a timeline model plus a per-instance scoreboard of expected vector results.
module tb_inta_cycle_sequencer;

  localparam int NCYC = 3000;
  localparam int NARR = NCYC + 32;

  typedef struct {
    logic [7:0]  vec;
    logic [15:0] ca;
    logic        sp;
    int          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst, int_in, int_en, ack;
  logic [7:0] bus;

  logic [1:0] inta_w, lock_w, busy_w, vv_w, sp_w;
  logic [7:0]  vec_w [2];
  logic [15:0] ca_w  [2];

  always #5 clk = ~clk;

  inta_cycle_sequencer #(.PULSE_W(2), .GAP_W(2), .MODE_8080(1'b0)) u_dut86 (
    .clk(clk), .rst(rst), .INT(int_in), .int_enable(int_en), .sys_DataLine(bus),
    .vector_ack(ack), .INTA(inta_w[0]), .LOCK(lock_w[0]), .busy(busy_w[0]),
    .vector_valid(vv_w[0]), .vector(vec_w[0]), .call_addr(ca_w[0]), .spurious(sp_w[0])
  );

  inta_cycle_sequencer #(.PULSE_W(3), .GAP_W(1), .MODE_8080(1'b1)) u_dut80 (
    .clk(clk), .rst(rst), .INT(int_in), .int_enable(int_en), .sys_DataLine(bus),
    .vector_ack(ack), .INTA(inta_w[1]), .LOCK(lock_w[1]), .busy(busy_w[1]),
    .vector_valid(vv_w[1]), .vector(vec_w[1]), .call_addr(ca_w[1]), .spurious(sp_w[1])
  );

  // Pre-planned stimulus: value at index k is what the DUT samples at edge k.
  bit         rst_a [NARR];
  bit         int_a [NARR];
  bit         en_a  [NARR];
  bit         ack_a [NARR];
  logic [7:0] bus_a [NARR];

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  bit          chk_on = 1'b0;
  int          cur_k = 0;
  bit          intq_m = 1'b0;
  bit          act   [2];
  int          s_e   [2];
  int          dn_e  [2];
  logic [7:0]  hv    [2];
  logic [15:0] hca   [2];
  logic        hsp   [2];
  logic        e_inta[2];
  logic        e_lock[2];
  logic        e_busy[2];
  logic        e_vv  [2];
  logic        vv_prev[2];

  function automatic int pw(input int m);
    return (m == 0) ? 2 : 3;
  endfunction
  function automatic int gw(input int m);
    return (m == 0) ? 2 : 1;
  endfunction
  function automatic bit md(input int m);
    return (m == 1);
  endfunction

  task automatic chk(input string nm, input int m, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d edge %0d: got %h expected %h", nm, m, cur_k, got, want);
    end
  endtask

  task automatic drive(input int k);
    rst    = rst_a[k];
    int_in = int_a[k];
    int_en = en_a[k];
    ack    = ack_a[k];
    bus    = bus_a[k];
  endtask

  // Model: a sequence started at edge s holds INTA low for offsets [0,P), [P+G,2P+G) and,
  // in 8080 mode, [2P+2G,3P+2G); each pulse's byte is the bus value at the edge ending it.
  task automatic model_step(input int k);
    int p, g, dur, o;
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      p   = pw(m);
      g   = gw(m);
      dur = md(m) ? 3 * p + 2 * g : 2 * p + g;
      if (rst_a[k]) begin
        act[m] = 1'b0;
        hv[m]  = '0;
        hca[m] = '0;
        hsp[m] = 1'b0;
        if (m == 0) q0.delete(); else q1.delete();
      end else if (!act[m]) begin
        if (intq_m && en_a[k]) begin
          act[m]  = 1'b1;
          s_e[m]  = k;
          dn_e[m] = k + dur;
          if (md(m)) begin
            e.vec = bus_a[k + p];
            e.ca  = {bus_a[k + 3 * p + 2 * g], bus_a[k + 2 * p + g]};
            e.sp  = (bus_a[k + p] != 8'hCD);
          end else begin
            e.vec = bus_a[k + 2 * p + g];
            e.ca  = 16'h0000;
            e.sp  = !int_a[k + p - 1];
          end
          e.done = k + dur;
          hv[m]  = e.vec;
          hca[m] = e.ca;
          hsp[m] = e.sp;
          if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
      end else if (k > dn_e[m] && ack_a[k]) begin
        act[m] = 1'b0;
      end

      if (act[m]) begin
        o         = k - s_e[m];
        e_busy[m] = 1'b1;
        e_inta[m] = !((o < p) || (o >= p + g && o < 2 * p + g) ||
                      (md(m) && o >= 2 * p + 2 * g && o < 3 * p + 2 * g));
        e_lock[m] = !(!md(m) && o < 2 * p + g);
        e_vv[m]   = (o >= dur);
      end else begin
        e_busy[m] = 1'b0;
        e_inta[m] = 1'b1;
        e_lock[m] = 1'b1;
        e_vv[m]   = 1'b0;
      end
    end
    intq_m = rst_a[k] ? 1'b0 : int_a[k];
  endtask

  // Monitor: per-cycle strobe checks plus scoreboard pop whenever vector_valid rises.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int m = 0; m < 2; m++) begin
        exp_t e;
        chk("inta", m, 16'(inta_w[m]), 16'(e_inta[m]));
        chk("lock", m, 16'(lock_w[m]), 16'(e_lock[m]));
        chk("busy", m, 16'(busy_w[m]), 16'(e_busy[m]));
        chk("vector_valid", m, 16'(vv_w[m]), 16'(e_vv[m]));
        if (!act[m] || e_vv[m]) begin
          chk("held_vector", m, 16'(vec_w[m]), 16'(hv[m]));
          chk("held_call_addr", m, ca_w[m], hca[m]);
          chk("held_spurious", m, 16'(sp_w[m]), 16'(hsp[m]));
        end
        if (vv_w[m] === 1'b1 && vv_prev[m] !== 1'b1) begin
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid dut%0d edge %0d: got valid expected none", m, cur_k);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk("sb_vector", m, 16'(vec_w[m]), 16'(e.vec));
            chk("sb_call_addr", m, ca_w[m], e.ca);
            chk("sb_spurious", m, 16'(sp_w[m]), 16'(e.sp));
            chk("sb_done_edge", m, 16'(cur_k), 16'(e.done));
          end
        end
        vv_prev[m] = vv_w[m];
      end
    end
  end

  initial begin
    for (int k = 0; k < NARR; k++) begin
      rst_a[k] = (k < 2) || ($urandom_range(0, 299) == 0);
      int_a[k] = ($urandom_range(0, 9) < 7);
      en_a[k]  = ((k % 500) >= 25) && ($urandom_range(0, 9) < 8);
      ack_a[k] = ($urandom_range(0, 3) == 0);
      bus_a[k] = ($urandom_range(0, 1) == 1) ? 8'hCD : 8'($urandom);
    end
    for (int m = 0; m < 2; m++) begin
      act[m]     = 1'b0;
      vv_prev[m] = 1'b0;
    end
    drive(0);
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cur_k = k;
      model_step(k);
      chk_on = 1'b1;
      drive(k + 1);
    end
    @(negedge clk);
    #1;
    // A result due before the run ended but never presented counts as lost.
    foreach (q0[i]) begin
      vectors++;
      if (q0[i].done < NCYC - 1) begin
        miscompares++;
        $display("FAIL lost_result dut0: got none expected valid at edge %0d", q0[i].done);
      end
    end
    foreach (q1[i]) begin
      vectors++;
      if (q1[i].done < NCYC - 1) begin
        miscompares++;
        $display("FAIL lost_result dut1: got none expected valid at edge %0d", q1[i].done);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
